// File: rtl/serial_divider_if.sv
// EX-stage <-> serial divider handshake: request, flush, operands, and result.
interface serial_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;

    modport master (
        output start, kill, op, A, B,
        input  Y, busy, done
    );

    modport slave (
        input  start, kill, op, A, B,
        output Y, busy, done
    );
endinterface

// File: rtl/serial_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with early completion for divide-by-zero and signed overflow.
module serial_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_divider_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    count_q, count_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fix_signed;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // Operand conditioning for the request currently on the bus.
    always_comb begin
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.A[WIDTH-1];
        b_neg     = in_signed & bus.B[WIDTH-1];
        a_mag     = a_neg ? (~bus.A + 1'b1) : bus.A;
        b_mag     = b_neg ? (~bus.B + 1'b1) : bus.B;
    end

    // One restoring step; the subtraction only fits WIDTH bits when it is taken,
    // which is the only case its result is used.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        rem_sub = shifted[WIDTH-1:0] - div_q;
    end

    always_comb begin
        fix_signed = ~op_q[0];
        quo_fixed  = (fix_signed && qsign_q) ? (~quo_q + 1'b1) : quo_q;
        rem_fixed  = (fix_signed && rsign_q) ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        count_d = count_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        y_d     = y_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d    = bus.op;
                    quo_d   = a_mag;
                    div_d   = b_mag;
                    qsign_d = a_neg ^ b_neg;
                    rsign_d = a_neg;
                    rem_d   = '0;
                    count_d = '0;
                    if (bus.B == '0) begin
                        y_d     = bus.op[1] ? bus.A : '1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (in_signed && bus.A == MOST_NEG && bus.B == '1) begin
                        y_d     = bus.op[1] ? '0 : MOST_NEG;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    if (shifted >= {1'b0, div_q}) begin
                        rem_d = rem_sub;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    y_d     = op_q[1] ? rem_fixed : quo_fixed;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            count_q <= count_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
